// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencing controller:
// instruction opcodes/functs, FSM states, instruction classes and the
// control-field encodings driven toward the datapath.
package mc_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;  // bgezal; rt is not visible here, so the opcode alone selects it
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR     = 6'b001000;
    localparam logic [5:0] FN_ADDU   = 6'b100001;
    localparam logic [5:0] FN_SUBU   = 6'b100011;
    localparam logic [5:0] FN_SLT    = 6'b101010;

    // FSM state encoding (also exported on the debug port)
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXE    = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // Instruction classes: everything the sequencer needs to know
    typedef enum logic [3:0] {
        CLS_ALU_R   = 4'd0,
        CLS_ALU_I   = 4'd1,   // ori, lui, addiu
        CLS_ADDI    = 4'd2,
        CLS_LW      = 4'd3,
        CLS_SW      = 4'd4,
        CLS_BEQ     = 4'd5,
        CLS_BGEZAL  = 4'd6,
        CLS_J       = 4'd7,
        CLS_JAL     = 4'd8,
        CLS_JR      = 4'd9,
        CLS_ILLEGAL = 4'd10
    } inst_class_t;

    // ALU operation select
    localparam logic [2:0] ALU_OP_ADD   = 3'b000;
    localparam logic [2:0] ALU_OP_SUB   = 3'b001;
    localparam logic [2:0] ALU_OP_OR    = 3'b010;
    localparam logic [2:0] ALU_OP_SLT   = 3'b011;
    localparam logic [2:0] ALU_OP_ADDV  = 3'b100;
    localparam logic [2:0] ALU_OP_BGEZ  = 3'b101;
    localparam logic [2:0] ALU_OP_ZERO  = 3'b111;

    // Immediate extension select
    localparam logic [1:0] EXT_ZERO     = 2'b00;
    localparam logic [1:0] EXT_SIGN     = 2'b01;
    localparam logic [1:0] EXT_HI       = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    // Register-file destination select
    localparam logic [1:0] REGDST_RT    = 2'b00;
    localparam logic [1:0] REGDST_RD    = 2'b01;
    localparam logic [1:0] REGDST_RA    = 2'b10;
    localparam logic [1:0] REGDST_R30   = 2'b11;

    // Write-back data select
    localparam logic [1:0] WB_ALU       = 2'b00;
    localparam logic [1:0] WB_MEM       = 2'b01;
    localparam logic [1:0] WB_LINK      = 2'b10;
    localparam logic [1:0] WB_ONE       = 2'b11;

    // True for classes that end their instruction in DECODE
    function automatic logic ends_in_decode(input inst_class_t cls);
        logic res;
        case (cls)
            CLS_J, CLS_JAL, CLS_JR, CLS_ILLEGAL: res = 1'b1;
            default:                             res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: classifies opcode/funct and produces
// the ALU controls used while the instruction is in EXE/MEM/WB.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output inst_class_t inst_class,
    output logic [2:0]  alu_op,
    output logic [1:0]  ext_op,
    output logic        alu_src,
    output logic        is_illegal
);

    // Map opcode/funct onto a class and its ALU/extension controls
    always_comb begin
        inst_class = CLS_ILLEGAL;
        alu_op     = ALU_OP_ZERO;
        ext_op     = EXT_ZERO;
        alu_src    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin inst_class = CLS_ALU_R; alu_op = ALU_OP_ADD; end
                    FN_SUBU: begin inst_class = CLS_ALU_R; alu_op = ALU_OP_SUB; end
                    FN_SLT:  begin inst_class = CLS_ALU_R; alu_op = ALU_OP_SLT; end
                    FN_JR:   begin inst_class = CLS_JR;    alu_op = ALU_OP_ZERO; end
                    default: begin inst_class = CLS_ILLEGAL; alu_op = ALU_OP_ZERO; end
                endcase
            end
            OP_ORI:    begin inst_class = CLS_ALU_I;  alu_op = ALU_OP_OR;   ext_op = EXT_ZERO; alu_src = 1'b1; end
            OP_LUI:    begin inst_class = CLS_ALU_I;  alu_op = ALU_OP_ADD;  ext_op = EXT_HI;   alu_src = 1'b1; end
            OP_ADDIU:  begin inst_class = CLS_ALU_I;  alu_op = ALU_OP_ADD;  ext_op = EXT_SIGN; alu_src = 1'b1; end
            OP_ADDI:   begin inst_class = CLS_ADDI;   alu_op = ALU_OP_ADDV; ext_op = EXT_SIGN; alu_src = 1'b1; end
            OP_LW:     begin inst_class = CLS_LW;     alu_op = ALU_OP_ADD;  ext_op = EXT_SIGN; alu_src = 1'b1; end
            OP_SW:     begin inst_class = CLS_SW;     alu_op = ALU_OP_ADD;  ext_op = EXT_SIGN; alu_src = 1'b1; end
            OP_BEQ:    begin inst_class = CLS_BEQ;    alu_op = ALU_OP_SUB;  ext_op = EXT_SIGN; alu_src = 1'b0; end
            OP_REGIMM: begin inst_class = CLS_BGEZAL; alu_op = ALU_OP_BGEZ; ext_op = EXT_SIGN; alu_src = 1'b0; end
            OP_J:      begin inst_class = CLS_J;      alu_op = ALU_OP_ZERO; end
            OP_JAL:    begin inst_class = CLS_JAL;    alu_op = ALU_OP_ZERO; end
            default:   begin inst_class = CLS_ILLEGAL; alu_op = ALU_OP_ZERO; end
        endcase
    end

    assign is_illegal = (inst_class == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencing controller. Steps each instruction through
// FETCH/DECODE/EXE/MEM/WB, drives per-cycle datapath enables combinationally
// from the current state, and stalls on the instruction/data ready handshakes
// with a saturating wait counter and a sticky timeout flag.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       rs_neg,
    input  logic       overflow,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       imem_read,
    output logic       dmem_read,
    output logic       dmem_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic [1:0] ext_op,
    output logic       illegal,
    output logic       mem_timeout,
    output logic [2:0] state
);

    // Wait counter is wide enough for WAIT_MAX, never wider than the datapath
    localparam int CNT_RAW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam int CNT_W   = (CNT_RAW < DATA_W) ? CNT_RAW : DATA_W;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);

    state_t            state_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic              mem_timeout_r;
    logic              stall_s;

    inst_class_t       cls_s;
    logic [2:0]        dec_alu_op_s;
    logic [1:0]        dec_ext_op_s;
    logic              dec_alu_src_s;
    logic              dec_illegal_s;

    logic              pc_write_s;
    logic [1:0]        pc_src_s;
    logic              ir_write_s;
    logic              imem_read_s;
    logic              dmem_read_s;
    logic              dmem_write_s;
    logic              reg_write_s;
    logic [1:0]        reg_dst_s;
    logic [1:0]        mem_to_reg_s;
    logic              alu_src_s;
    logic [2:0]        alu_op_s;
    logic [1:0]        ext_op_s;
    logic              illegal_s;

    mc_decode u_decode (
        .opcode     (opcode),
        .funct      (funct),
        .inst_class (cls_s),
        .alu_op     (dec_alu_op_s),
        .ext_op     (dec_ext_op_s),
        .alu_src    (dec_alu_src_s),
        .is_illegal (dec_illegal_s)
    );

    // A memory stall is FETCH or MEM waiting on its ready handshake
    always_comb begin
        if (state_r == ST_FETCH) begin
            stall_s = ~imem_ready;
        end else if (state_r == ST_MEM) begin
            stall_s = ~dmem_ready;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Sequencer: state transitions, stall wait counter and sticky timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_FETCH;
            wait_cnt_r    <= '0;
            mem_timeout_r <= 1'b0;
        end else begin
            if (stall_s) begin
                if (wait_cnt_r != WAIT_LIMIT) begin
                    wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                end else begin
                    wait_cnt_r <= wait_cnt_r;
                end
                // The stall that brings the count to WAIT_MAX raises the flag
                if (wait_cnt_r >= WAIT_LIMIT - CNT_W'(1)) begin
                    mem_timeout_r <= 1'b1;
                end else begin
                    mem_timeout_r <= mem_timeout_r;
                end
            end else begin
                wait_cnt_r    <= '0;
                mem_timeout_r <= mem_timeout_r;
            end

            case (state_r)
                ST_FETCH: begin
                    if (imem_ready) begin
                        state_r <= ST_DECODE;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    if (ends_in_decode(cls_s)) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_EXE;
                    end
                end
                ST_EXE: begin
                    case (cls_s)
                        CLS_BEQ, CLS_BGEZAL: state_r <= ST_FETCH;
                        CLS_LW, CLS_SW:      state_r <= ST_MEM;
                        default:             state_r <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (!dmem_ready) begin
                        state_r <= ST_MEM;
                    end else if (cls_s == CLS_LW) begin
                        state_r <= ST_WB;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_WB:   state_r <= ST_FETCH;
                default: state_r <= ST_FETCH;
            endcase
        end
    end

    // Per-state datapath controls; everything is held inactive while in reset
    always_comb begin
        pc_write_s   = 1'b0;
        pc_src_s     = PCSRC_SEQ;
        ir_write_s   = 1'b0;
        imem_read_s  = 1'b0;
        dmem_read_s  = 1'b0;
        dmem_write_s = 1'b0;
        reg_write_s  = 1'b0;
        reg_dst_s    = REGDST_RT;
        mem_to_reg_s = WB_ALU;
        alu_src_s    = 1'b0;
        alu_op_s     = ALU_OP_ZERO;
        ext_op_s     = EXT_ZERO;
        illegal_s    = 1'b0;
        if (!rst_n) begin
            alu_op_s = ALU_OP_ZERO;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    imem_read_s = 1'b1;
                    if (imem_ready) begin
                        ir_write_s = 1'b1;
                        pc_write_s = 1'b1;
                        pc_src_s   = PCSRC_SEQ;
                    end else begin
                        ir_write_s = 1'b0;
                        pc_write_s = 1'b0;
                    end
                end
                ST_DECODE: begin
                    case (cls_s)
                        CLS_J: begin
                            pc_write_s = 1'b1;
                            pc_src_s   = PCSRC_JUMP;
                        end
                        CLS_JAL: begin
                            pc_write_s   = 1'b1;
                            pc_src_s     = PCSRC_JUMP;
                            reg_write_s  = 1'b1;
                            reg_dst_s    = REGDST_RA;
                            mem_to_reg_s = WB_LINK;
                        end
                        CLS_JR: begin
                            pc_write_s = 1'b1;
                            pc_src_s   = PCSRC_REG;
                        end
                        default: begin
                            illegal_s = dec_illegal_s;
                        end
                    endcase
                end
                ST_EXE: begin
                    alu_op_s  = dec_alu_op_s;
                    alu_src_s = dec_alu_src_s;
                    ext_op_s  = dec_ext_op_s;
                    case (cls_s)
                        CLS_BEQ: begin
                            pc_write_s = zero;
                            pc_src_s   = PCSRC_BRANCH;
                        end
                        CLS_BGEZAL: begin
                            // Link is written whether or not the branch is taken
                            reg_write_s  = 1'b1;
                            reg_dst_s    = REGDST_RA;
                            mem_to_reg_s = WB_LINK;
                            pc_write_s   = ~rs_neg;
                            pc_src_s     = PCSRC_BRANCH;
                        end
                        default: begin
                            pc_write_s = 1'b0;
                        end
                    endcase
                end
                ST_MEM: begin
                    alu_op_s     = dec_alu_op_s;
                    alu_src_s    = dec_alu_src_s;
                    ext_op_s     = dec_ext_op_s;
                    dmem_read_s  = (cls_s == CLS_LW);
                    dmem_write_s = (cls_s == CLS_SW);
                end
                ST_WB: begin
                    alu_op_s    = dec_alu_op_s;
                    alu_src_s   = dec_alu_src_s;
                    ext_op_s    = dec_ext_op_s;
                    reg_write_s = 1'b1;
                    if ((cls_s == CLS_ADDI) && overflow) begin
                        // Overflowing addi leaves rt untouched and flags $30 = 1
                        reg_dst_s    = REGDST_R30;
                        mem_to_reg_s = WB_ONE;
                    end else if (cls_s == CLS_ALU_R) begin
                        reg_dst_s    = REGDST_RD;
                        mem_to_reg_s = WB_ALU;
                    end else if (cls_s == CLS_LW) begin
                        reg_dst_s    = REGDST_RT;
                        mem_to_reg_s = WB_MEM;
                    end else begin
                        reg_dst_s    = REGDST_RT;
                        mem_to_reg_s = WB_ALU;
                    end
                end
                default: begin
                    alu_op_s = ALU_OP_ZERO;
                end
            endcase
        end
    end

    assign pc_write    = pc_write_s;
    assign pc_src      = pc_src_s;
    assign ir_write    = ir_write_s;
    assign imem_read   = imem_read_s;
    assign dmem_read   = dmem_read_s;
    assign dmem_write  = dmem_write_s;
    assign reg_write   = reg_write_s;
    assign reg_dst     = reg_dst_s;
    assign mem_to_reg  = mem_to_reg_s;
    assign alu_src     = alu_src_s;
    assign alu_op      = alu_op_s;
    assign ext_op      = ext_op_s;
    assign illegal     = illegal_s;
    assign mem_timeout = mem_timeout_r;
    assign state       = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios followed
// by randomized instruction streams, compared against an instruction-level
// reference model (phase list per instruction + expected controls per phase).
module tb_multicycle_controller;

    localparam int WAIT_MAX = 15;

    // Instruction kinds known to the reference model
    localparam int K_R = 0, K_IMM = 1, K_ADDI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5;
    localparam int K_BGEZAL = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_ILL = 10;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         kind;
        int         aluop;
        int         ext;
    } instr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, rs_neg, overflow, imem_ready, dmem_ready;
    logic       pc_write, ir_write, imem_read, dmem_read, dmem_write, reg_write;
    logic [1:0] pc_src, reg_dst, mem_to_reg, ext_op;
    logic       alu_src, illegal, mem_timeout;
    logic [2:0] alu_op, state;

    int n_checks = 0;
    int n_pass   = 0;
    int streak   = 0;
    bit exp_to   = 1'b0;

    always #5 clk = ~clk;

    multicycle_controller #(.DATA_W(32), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .rs_neg(rs_neg), .overflow(overflow),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .imem_read(imem_read), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op),
        .illegal(illegal), .mem_timeout(mem_timeout), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction table: 14 legal instructions plus two undefined encodings
    function automatic instr_t lookup(input int idx);
        instr_t e;
        e.fn = 6'($urandom_range(0, 63));
        e.ext = 0;
        e.aluop = 7;
        case (idx)
            0:  begin e.op = 6'h00; e.fn = 6'h21; e.kind = K_R;      e.aluop = 0; end // addu
            1:  begin e.op = 6'h00; e.fn = 6'h23; e.kind = K_R;      e.aluop = 1; end // subu
            2:  begin e.op = 6'h00; e.fn = 6'h2A; e.kind = K_R;      e.aluop = 3; end // slt
            3:  begin e.op = 6'h00; e.fn = 6'h08; e.kind = K_JR;                  end // jr
            4:  begin e.op = 6'h0D; e.kind = K_IMM;  e.aluop = 2; e.ext = 0;      end // ori
            5:  begin e.op = 6'h0F; e.kind = K_IMM;  e.aluop = 0; e.ext = 2;      end // lui
            6:  begin e.op = 6'h09; e.kind = K_IMM;  e.aluop = 0; e.ext = 1;      end // addiu
            7:  begin e.op = 6'h23; e.kind = K_LW;   e.aluop = 0; e.ext = 1;      end // lw
            8:  begin e.op = 6'h2B; e.kind = K_SW;   e.aluop = 0; e.ext = 1;      end // sw
            9:  begin e.op = 6'h04; e.kind = K_BEQ;  e.aluop = 1;                 end // beq
            10: begin e.op = 6'h01; e.kind = K_BGEZAL; e.aluop = 5;               end // bgezal
            11: begin e.op = 6'h02; e.kind = K_J;                                 end // j
            12: begin e.op = 6'h03; e.kind = K_JAL;                               end // jal
            13: begin e.op = 6'h08; e.kind = K_ADDI; e.aluop = 4; e.ext = 1;      end // addi
            14: begin e.op = 6'h3F; e.kind = K_ILL;                               end // undefined opcode
            default: begin e.op = 6'h00; e.fn = 6'h3F; e.kind = K_ILL;            end // undefined funct
        endcase
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_enables"}, {pc_write, ir_write, imem_read, dmem_read, dmem_write, reg_write, illegal}, 7'd0);
        check({tag, "_selects"}, {pc_src, reg_dst, mem_to_reg, ext_op, alu_src}, 9'd0);
        check({tag, "_alu_op"}, alu_op, 3'b111);
        check({tag, "_state"}, state, 3'd0);
        check({tag, "_timeout"}, mem_timeout, 1'b0);
    endtask

    // Run one instruction; zero_v/neg_v/ovf_v < 0 means randomize every cycle.
    // Entered and left at posedge+1 with the DUT expected in FETCH.
    task automatic run_instr(input instr_t e, input int fetch_stall, input int mem_stall,
                             input int zero_v, input int neg_v, input int ovf_v, input bit abort_mem);
        int phases[$];
        int fs = fetch_stall;
        int ms = mem_stall;
        int i = 0;
        int p;
        bit stall;
        bit e_pcw, e_irw, e_imr, e_dmr, e_dmw, e_rw, e_ill;
        int e_pcs, e_rd, e_m2r;
        bit chk_pcs;

        phases = {0, 1};
        case (e.kind)
            K_J, K_JAL, K_JR, K_ILL: ;
            K_BEQ, K_BGEZAL:         phases.push_back(2);
            K_LW:                    begin phases.push_back(2); phases.push_back(3); phases.push_back(4); end
            K_SW:                    begin phases.push_back(2); phases.push_back(3); end
            default:                 begin phases.push_back(2); phases.push_back(4); end
        endcase

        opcode = e.op;
        funct  = e.fn;
        while (i < phases.size()) begin
            p = phases[i];
            zero     = (zero_v < 0) ? 1'($urandom_range(0, 1)) : 1'(zero_v);
            rs_neg   = (neg_v  < 0) ? 1'($urandom_range(0, 1)) : 1'(neg_v);
            overflow = (ovf_v  < 0) ? 1'($urandom_range(0, 1)) : 1'(ovf_v);
            imem_ready = (p == 0) ? (fs == 0) : 1'($urandom_range(0, 1));
            dmem_ready = (p == 3) ? (ms == 0) : 1'($urandom_range(0, 1));
            stall = ((p == 0) && (fs > 0)) || ((p == 3) && (ms > 0));

            e_pcw = 0; e_irw = 0; e_imr = 0; e_dmr = 0; e_dmw = 0; e_rw = 0; e_ill = 0;
            e_pcs = 0; e_rd = 0; e_m2r = 0; chk_pcs = 0;
            case (p)
                0: begin
                    e_imr = 1;
                    if (!stall) begin e_irw = 1; e_pcw = 1; e_pcs = 0; end
                end
                1: begin
                    if (e.kind == K_J)   begin e_pcw = 1; e_pcs = 2; end
                    if (e.kind == K_JAL) begin e_pcw = 1; e_pcs = 2; e_rw = 1; e_rd = 2; e_m2r = 2; end
                    if (e.kind == K_JR)  begin e_pcw = 1; e_pcs = 3; end
                    if (e.kind == K_ILL) e_ill = 1;
                end
                2: begin
                    if (e.kind == K_BEQ) begin e_pcw = zero; e_pcs = 1; chk_pcs = 1; end
                    if (e.kind == K_BGEZAL) begin
                        e_rw = 1; e_rd = 2; e_m2r = 2; e_pcw = !rs_neg; e_pcs = 1; chk_pcs = 1;
                    end
                end
                3: begin
                    e_dmr = (e.kind == K_LW);
                    e_dmw = (e.kind == K_SW);
                end
                default: begin
                    e_rw  = 1;
                    e_rd  = (e.kind == K_R) ? 1 : 0;
                    e_m2r = (e.kind == K_LW) ? 1 : 0;
                    if (e.kind == K_ADDI && overflow) begin e_rd = 3; e_m2r = 3; end
                end
            endcase

            @(negedge clk);
            check("state", state, p);
            check("enables", {pc_write, ir_write, imem_read, dmem_read, dmem_write, reg_write, illegal},
                  {e_pcw, e_irw, e_imr, e_dmr, e_dmw, e_rw, e_ill});
            if (e_pcw || chk_pcs) check("pc_src", pc_src, e_pcs);
            if (e_rw) begin
                check("reg_dst", reg_dst, e_rd);
                check("mem_to_reg", mem_to_reg, e_m2r);
            end
            if (p == 2 || p == 4) check("alu_op", alu_op, e.aluop);
            if (p == 2) begin
                check("alu_src", alu_src, (e.kind == K_R || e.kind == K_BEQ || e.kind == K_BGEZAL) ? 0 : 1);
                if (e.kind == K_IMM || e.kind == K_ADDI || e.kind == K_LW || e.kind == K_SW)
                    check("ext_op", ext_op, e.ext);
            end
            check("mem_timeout", mem_timeout, exp_to);

            if (abort_mem && p == 3) begin
                #1 rst_n = 1'b0;
                #1;
                streak = 0;
                exp_to = 1'b0;
                check_reset_outputs("abort");
                @(posedge clk);
                #1;
                check_reset_outputs("abort_hold");
                rst_n = 1'b1;
                return;
            end

            @(posedge clk);
            #1;
            if (stall) begin
                streak++;
                if (streak >= WAIT_MAX) exp_to = 1'b1;
                if (p == 0) fs--; else ms--;
            end else begin
                streak = 0;
                i++;
            end
        end
    endtask

    // Watchdog: the run must never hang
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        instr_t e;
        rst_n = 1'b0; opcode = 6'h0; funct = 6'h0; zero = 1'b0; rs_neg = 1'b0;
        overflow = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: addu, no stalls
        run_instr(lookup(0), 0, 0, -1, -1, -1, 1'b0);
        // 2: lw with three data stall cycles
        run_instr(lookup(7), 0, 3, -1, -1, -1, 1'b0);
        // 3: beq taken then not taken
        run_instr(lookup(9), 0, 0, 1, -1, -1, 1'b0);
        run_instr(lookup(9), 0, 0, 0, -1, -1, 1'b0);
        // 4: addi overflowing, then not overflowing
        run_instr(lookup(13), 0, 0, -1, -1, 1, 1'b0);
        run_instr(lookup(13), 0, 0, -1, -1, 0, 1'b0);
        // 5: jal, then bgezal with negative rs, then with non-negative rs
        run_instr(lookup(12), 0, 0, -1, -1, -1, 1'b0);
        run_instr(lookup(10), 0, 0, -1, 1, -1, 1'b0);
        run_instr(lookup(10), 0, 0, -1, 0, -1, 1'b0);
        // 6: undefined opcode and funct, fetch timeout, reset mid-MEM
        run_instr(lookup(14), 0, 0, -1, -1, -1, 1'b0);
        run_instr(lookup(15), 0, 0, -1, -1, -1, 1'b0);
        run_instr(lookup(0), 16, 0, -1, -1, -1, 1'b0);
        run_instr(lookup(8), 0, 2, -1, -1, -1, 1'b0);
        run_instr(lookup(7), 0, 5, -1, -1, -1, 1'b1);

        // Randomized instruction stream with occasional aborts
        for (int n = 0; n < 80; n++) begin
            e = lookup(int'($urandom_range(0, 15)));
            run_instr(e, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1, -1, -1,
                      (e.kind == K_LW || e.kind == K_SW) && ($urandom_range(0, 7) == 0));
        end
        run_instr(lookup(1), 0, 0, -1, -1, -1, 1'b0);
        // A long data stall near the end exercises timeout from MEM
        run_instr(lookup(8), 0, 17, -1, -1, -1, 1'b0);
        run_instr(lookup(2), 0, 0, -1, -1, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
